afifo_reader: RTL and testbench

AFIFO_READER -- requirements
Module: afifo_reader

---
 rtl/afifo_pkg.sv | 18 +
 rtl/afifo_skid_buf.sv | 55 +++++
 rtl/afifo_reader.sv | 89 ++++++++
 tb/tb_afifo_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared constants for the async-FIFO reader: FSM encodings and output buffer depth.
package afifo_pkg;

   typedef logic [1:0] afifo_state_t;

   localparam afifo_state_t ST_IDLE = 2'd0;
   localparam afifo_state_t ST_RUN  = 2'd1;
   localparam afifo_state_t ST_DONE = 2'd2;

   localparam int BUF_DEPTH = 2;

   // True when one more pop can be issued without overflowing the output buffer.
   function automatic logic buf_has_room(input logic [1:0] occ_after_read,
                                         input logic inflight);
      return ({1'b0, occ_after_read} + {2'b00, inflight}) < 3'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/afifo_skid_buf.sv
// Two-entry output buffer: registered head word and valid, no combinational path from head_ready.
module afifo_skid_buf import afifo_pkg::*; #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data,
   input  logic                  head_ready,
   output logic [1:0]            occupancy
);

   logic [DATA_WIDTH-1:0] slot0_q;
   logic [DATA_WIDTH-1:0] slot1_q;
   logic [1:0]            occ_q;
   logic                  rd;

   assign rd         = head_valid & head_ready;
   assign head_valid = (occ_q != 2'd0);
   assign head_data  = slot0_q;
   assign occupancy  = occ_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         occ_q   <= 2'd0;
      end else begin
         case ({wr_en, rd})
            2'b10: begin
               if (occ_q == 2'd0) slot0_q <= wr_data;
               else               slot1_q <= wr_data;
               if (occ_q != 2'(BUF_DEPTH)) occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               slot0_q <= slot1_q;
               occ_q   <= occ_q - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new word lands behind whatever remains
               if (occ_q == 2'd1) begin
                  slot0_q <= wr_data;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/afifo_reader.sv
// Pops a fixed-length packet from a FIFO and streams it out through a 2-entry skid buffer.
//
//   state   | meaning
//   IDLE    | waiting for start; pkt_len sampled on accept
//   RUN     | popping FIFO and streaming words until the last one transfers
//   DONE    | one-cycle done pulse, then back to IDLE
module afifo_reader import afifo_pkg::*; #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] pkt_len,
   output logic [DATA_WIDTH-1:0]  o_data,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_last,
   output logic                   busy,
   output logic                   done
);

   afifo_state_t         state_q;
   logic [COUNT_WIDTH:0] len_q;
   logic [COUNT_WIDTH:0] req_cnt_q;
   logic [COUNT_WIDTH:0] xfer_cnt_q;
   logic                 inflight_q;
   logic [1:0]           occ;
   logic [1:0]           occ_after_read;
   logic                 xfer;

   assign xfer = o_valid & o_ready;

   // Counting the slot freed by this cycle's transfer keeps a full 1 word/cycle stream.
   assign occ_after_read = occ - {1'b0, xfer};

   assign fifo_rd_en = rst & (state_q == ST_RUN) & ~fifo_empty & (req_cnt_q != len_q)
                     & buf_has_room(occ_after_read, inflight_q);

   assign o_last = o_valid & (xfer_cnt_q == (len_q - (COUNT_WIDTH+1)'(1)));
   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         req_cnt_q  <= '0;
         xfer_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= fifo_rd_en;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  len_q      <= (pkt_len == '0) ? {1'b1, {COUNT_WIDTH{1'b0}}} : {1'b0, pkt_len};
                  req_cnt_q  <= '0;
                  xfer_cnt_q <= '0;
               end
            end
            ST_RUN: begin
               if (fifo_rd_en) req_cnt_q  <= req_cnt_q + (COUNT_WIDTH+1)'(1);
               if (xfer)       xfer_cnt_q <= xfer_cnt_q + (COUNT_WIDTH+1)'(1);
               if (xfer && o_last) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   afifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (inflight_q),
      .wr_data    (fifo_data),
      .head_valid (o_valid),
      .head_data  (o_data),
      .head_ready (o_ready),
      .occupancy  (occ)
   );

endmodule

// File: tb/tb_afifo_reader.sv
// Directed bench for afifo_reader with a behavioural FIFO stepped once per clock.
module tb_afifo_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_data;
   logic       start;
   logic [3:0] pkt_len;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ready;
   logic       o_last;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   afifo_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .start      (start),
      .pkt_len    (pkt_len),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_last     (o_last),
      .busy       (busy),
      .done       (done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int pops = 0;
   int rd_while_empty = 0;
   int done_cyc = -1;
   logic pop_now;
   logic s_valid, s_ready, s_last;
   logic [7:0] s_data;

   logic [7:0] fq[$];
   logic [7:0] rx_data[$];
   logic       rx_last[$];
   int         rx_cyc[$];

   // Samples outputs mid-cycle, then advances one edge and models the FIFO read latency.
   task automatic tick();
      @(negedge clk);
      s_valid = o_valid;
      s_ready = o_ready;
      s_data  = o_data;
      s_last  = o_last;
      if (fifo_rd_en && fifo_empty) rd_while_empty++;
      pop_now = fifo_rd_en && !fifo_empty;
      if (o_valid && o_ready && rst) begin
         rx_data.push_back(o_data);
         rx_last.push_back(o_last);
         rx_cyc.push_back(cyc);
      end
      if (done) done_cyc = cyc;
      @(posedge clk);
      #1;
      if (pop_now && fq.size() > 0) begin
         pops++;
         fifo_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
      cyc++;
   endtask

   task automatic push(input logic [7:0] v);
      fq.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic prep();
      fq.delete();
      fifo_empty = 1'b1;
      rx_data.delete();
      rx_last.delete();
      rx_cyc.delete();
      done_cyc = -1;
      pops = 0;
      rd_while_empty = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; o_ready = 1'b0; pkt_len = 4'd0;
      fifo_empty = 1'b1; fifo_data = 8'h00;
      tick(); tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL reset_o_data: got %h want 00", o_data); end
      n_cmp++; if (o_last !== 1'b0) begin n_bad++; $display("FAIL reset_o_last: got %b want 0", o_last); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_streaming();
      logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int c0;
      prep();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      o_ready = 1'b1; pkt_len = 4'd4; start = 1'b1;
      c0 = cyc;
      tick();
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stream_busy: got %b want 1", busy); end
      for (int i = 0; i < 30 && done_cyc < 0; i++) tick();
      n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL stream_timeout: done never seen"); end
      n_cmp++; if (rx_data.size() !== 4) begin n_bad++; $display("FAIL stream_count: got %0d want 4", rx_data.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rx_data[i] !== exp[i]) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, rx_data[i], exp[i]); end
         n_cmp++; if (rx_last[i] !== (i == 3)) begin n_bad++; $display("FAIL stream_last[%0d]: got %b want %b", i, rx_last[i], i == 3); end
         n_cmp++; if (rx_cyc[i] !== c0 + 3 + i) begin n_bad++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, rx_cyc[i], c0 + 3 + i); end
      end
      n_cmp++; if (done_cyc !== rx_cyc[3] + 1) begin n_bad++; $display("FAIL stream_done_cycle: got %0d want %0d", done_cyc, rx_cyc[3] + 1); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stream_idle: got done=%b busy=%b want 0 0", done, busy); end
      n_cmp++; if (fq.size() !== 1 || fq[0] !== 8'h55) begin n_bad++; $display("FAIL stream_surplus: got size %0d want 1 with 55", fq.size()); end
   endtask

   task automatic test_backpressure();
      logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       prev_hold;
      logic [7:0] prev_data;
      int max_out;
      prep();
      push(8'hA0); push(8'hA1); push(8'hA2);
      pkt_len = 4'd3; start = 1'b1; o_ready = 1'b1;
      tick();
      start = 1'b0;
      prev_hold = 1'b0; prev_data = 8'h00; max_out = 0;
      for (int i = 0; i < 40 && done_cyc < 0; i++) begin
         o_ready = pat[i % 6];
         tick();
         if (prev_hold) begin
            n_cmp++;
            if (s_valid !== 1'b1 || s_data !== prev_data) begin
               n_bad++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", s_valid, s_data, prev_data);
            end
         end
         prev_hold = s_valid && !s_ready;
         prev_data = s_data;
         if (pops - rx_data.size() > max_out) max_out = pops - rx_data.size();
      end
      o_ready = 1'b1;
      n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL bp_timeout: done never seen"); end
      n_cmp++; if (rx_data.size() !== 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", rx_data.size()); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rx_data[i] !== 8'hA0 + 8'(i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx_data[i], 8'hA0 + 8'(i)); end
      end
      n_cmp++; if (rx_last[2] !== 1'b1) begin n_bad++; $display("FAIL bp_last: got %b want 1", rx_last[2]); end
      n_cmp++; if (max_out > 2) begin n_bad++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
      tick();
   endtask

   task automatic test_underflow();
      prep();
      pkt_len = 4'd2; start = 1'b1; o_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_cmp++; if (pops !== 0) begin n_bad++; $display("FAIL uf_no_pop_while_empty: got %0d pops want 0", pops); end
      push(8'h5A);
      for (int i = 0; i < 10; i++) tick();
      push(8'h5B);
      for (int i = 0; i < 20 && done_cyc < 0; i++) tick();
      n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL uf_timeout: done never seen"); end
      n_cmp++; if (rd_while_empty !== 0) begin n_bad++; $display("FAIL uf_rd_en_empty: got %0d want 0", rd_while_empty); end
      n_cmp++; if (rx_data.size() !== 2 || rx_data[0] !== 8'h5A || rx_data[1] !== 8'h5B) begin
         n_bad++; $display("FAIL uf_data: got n=%0d %h %h want 2 5a 5b", rx_data.size(), rx_data[0], rx_data[1]);
      end
      n_cmp++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin n_bad++; $display("FAIL uf_last: got %b%b want 01", rx_last[0], rx_last[1]); end
      tick();
   endtask

   task automatic test_len_wrap();
      int n_last;
      prep();
      for (int i = 0; i < 16; i++) push(8'(i) + 8'h80);
      push(8'hEE);
      pkt_len = 4'd0; start = 1'b1; o_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 60 && done_cyc < 0; i++) tick();
      n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL wrap_timeout: done never seen"); end
      n_cmp++; if (rx_data.size() !== 16) begin n_bad++; $display("FAIL wrap_count: got %0d want 16", rx_data.size()); end
      n_last = 0;
      for (int i = 0; i < rx_data.size(); i++) begin
         n_cmp++; if (rx_data[i] !== 8'(i) + 8'h80) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rx_data[i], 8'(i) + 8'h80); end
         if (rx_last[i]) n_last++;
      end
      n_cmp++; if (rx_last[15] !== 1'b1 || n_last !== 1) begin n_bad++; $display("FAIL wrap_last: got last16=%b count=%0d want 1 1", rx_last[15], n_last); end
      n_cmp++; if (fq.size() !== 1) begin n_bad++; $display("FAIL wrap_surplus: got %0d left want 1", fq.size()); end
      tick();
   endtask

   task automatic test_ignored_start();
      prep();
      for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
      pkt_len = 4'd2; start = 1'b1; o_ready = 1'b1;
      tick();
      pkt_len = 4'd5;
      tick(); tick(); tick();
      start = 1'b0;
      for (int i = 0; i < 20 && done_cyc < 0; i++) tick();
      n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL ign_timeout: done never seen"); end
      n_cmp++; if (rx_data.size() !== 2) begin n_bad++; $display("FAIL ign_count: got %0d want 2", rx_data.size()); end
      n_cmp++; if (rx_last[1] !== 1'b1) begin n_bad++; $display("FAIL ign_last: got %b want 1", rx_last[1]); end
      n_cmp++; if (fq.size() !== 4) begin n_bad++; $display("FAIL ign_fifo_left: got %0d want 4", fq.size()); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n_rx;
      prep();
      push(8'hC0); push(8'hC1); push(8'hC2);
      pkt_len = 4'd3; start = 1'b1; o_ready = 1'b0;
      tick();
      start = 1'b0;
      s_valid = 1'b0;
      for (int i = 0; i < 10 && !s_valid; i++) tick();
      n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_timeout: o_valid never seen"); end
      rst = 1'b0;
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_o_valid: got %b want 0", o_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      rst = 1'b1; o_ready = 1'b1;
      n_rx = rx_data.size();
      for (int i = 0; i < 6; i++) tick();
      n_cmp++; if (rx_data.size() !== n_rx || o_valid !== 1'b0) begin
         n_bad++; $display("FAIL rmid_no_output: got %0d words v=%b want %0d v=0", rx_data.size(), o_valid, n_rx);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_underflow();
      test_len_wrap();
      test_ignored_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
